// File: rtl/run_dump_pkg.sv
// Shared FSM state encodings and dump-source tags for the run/dump harness controller.
package run_dump_pkg;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RESET    = 3'd1;
   localparam logic [2:0] S_RUN      = 3'd2;
   localparam logic [2:0] S_DUMP_RF  = 3'd3;
   localparam logic [2:0] S_DUMP_MEM = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic SRC_RF  = 1'b0;
   localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/dump_streamer.sv
// Walks RF entries then DMEM words, registering each read into a valid/ready output
// stage; the read pointer only advances when the output register is free to load.
module dump_streamer
   import run_dump_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int MEM_AW   = 16,
   parameter int RF_DEPTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              active,
   input  logic [MEM_AW:0]   mem_words,
   input  logic [DATA_W-1:0] rdata,
   output logic              rd_src,
   output logic [MEM_AW-1:0] rd_addr,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_src,
   output logic [MEM_AW-1:0] dout_addr,
   output logic              dout_last,
   output logic              fin
);

   localparam logic [MEM_AW:0] RF_LAST = (MEM_AW+1)'(RF_DEPTH - 1);

   logic            rd_more;
   logic            rf_end;
   logic            mem_end;
   logic            is_last;
   logic            load;
   logic [MEM_AW:0] addr_ext;

   assign addr_ext = {1'b0, rd_addr};
   assign rf_end   = (rd_src == SRC_RF) && (addr_ext == RF_LAST);
   assign mem_end  = (rd_src == SRC_MEM) && (addr_ext == mem_words - (MEM_AW+1)'(1));
   assign is_last  = (rf_end && (mem_words == '0)) || mem_end;
   assign load     = active && rd_more && (!dout_valid || dout_ready);
   assign fin      = dout_valid && dout_ready && dout_last;

   // Pointer sits at RF 0 whenever no dump is in progress, so the first dump cycle reads entry 0.
   always_ff @(posedge clk) begin
      if (rst || !active) begin
         rd_src  <= SRC_RF;
         rd_addr <= '0;
         rd_more <= 1'b1;
      end else if (load) begin
         if (is_last) begin
            rd_more <= 1'b0;
         end else if (rf_end) begin
            rd_src  <= SRC_MEM;
            rd_addr <= '0;
         end else begin
            rd_addr <= rd_addr + MEM_AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_src   <= SRC_RF;
         dout_addr  <= '0;
         dout_last  <= 1'b0;
      end else if (load) begin
         dout_valid <= 1'b1;
         dout_data  <= rdata;
         dout_src   <= rd_src;
         dout_addr  <= rd_addr;
         dout_last  <= is_last;
      end else if (dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/run_dump_ctrl.sv
// Run-and-dump controller: sequences CPU reset, runs until halt or watchdog, then
// freezes the CPU and streams the register file followed by a DMEM range.
module run_dump_ctrl
   import run_dump_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int RF_AW      = 5,
   parameter int MEM_AW     = 16,
   parameter int CNT_W      = 32,
   parameter int RST_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  max_cycles,
   input  logic [MEM_AW:0]   mem_words,
   output logic              cpu_rst_n,
   output logic              cpu_en,
   input  logic              cpu_halt,
   output logic [RF_AW-1:0]  rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [MEM_AW-1:0] dm_raddr,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_src,
   output logic [MEM_AW-1:0] dout_addr,
   output logic              dout_last,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int              RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
   localparam logic [MEM_AW:0] MEM_MAX  = {1'b1, {MEM_AW{1'b0}}};

   logic [2:0]        state;
   logic [RC_W-1:0]   rst_cnt;
   logic [CNT_W-1:0]  limit;
   logic [CNT_W-1:0]  cnt_inc;
   logic [MEM_AW:0]   mem_lim;
   logic [MEM_AW:0]   mem_clamped;
   logic              active;
   logic              rd_src;
   logic [MEM_AW-1:0] rd_addr;
   logic [DATA_W-1:0] rdata;
   logic              fin;

   // Any request with the top bit set is at least the full DMEM depth.
   assign mem_clamped = mem_words[MEM_AW] ? MEM_MAX : mem_words;
   assign cnt_inc     = cycle_count + CNT_W'(1);

   assign cpu_rst_n = !((state == S_IDLE) || (state == S_RESET));
   assign cpu_en    = (state == S_RUN);
   assign done      = (state == S_DONE);
   assign active    = (state == S_DUMP_RF) || (state == S_DUMP_MEM);

   assign rf_raddr  = (rd_src == SRC_RF)  ? rd_addr[RF_AW-1:0] : '0;
   assign dm_raddr  = (rd_src == SRC_MEM) ? rd_addr : '0;
   assign rdata     = (rd_src == SRC_MEM) ? dm_rdata : rf_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rst_cnt     <= '0;
         limit       <= '0;
         mem_lim     <= '0;
         cycle_count <= '0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state       <= S_RESET;
                  rst_cnt     <= '0;
                  limit       <= max_cycles;
                  mem_lim     <= mem_clamped;
                  cycle_count <= '0;
                  timeout     <= 1'b0;
               end
            end
            S_RESET: begin
               if (rst_cnt == RC_LAST) state <= S_RUN;
               else                    rst_cnt <= rst_cnt + RC_W'(1);
            end
            S_RUN: begin
               if (cycle_count != '1) cycle_count <= cnt_inc;
               // A wrapped cnt_inc at saturation can never equal a nonzero limit.
               if (cpu_halt) begin
                  state <= S_DUMP_RF;
               end else if ((limit != '0) && (cnt_inc == limit)) begin
                  state   <= S_DUMP_RF;
                  timeout <= 1'b1;
               end
            end
            S_DUMP_RF: begin
               if (fin)                    state <= S_DONE;
               else if (rd_src == SRC_MEM) state <= S_DUMP_MEM;
            end
            S_DUMP_MEM: begin
               if (fin) state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   dump_streamer #(
      .DATA_W   (DATA_W),
      .MEM_AW   (MEM_AW),
      .RF_DEPTH (1 << RF_AW)
   ) u_streamer (
      .clk        (clk),
      .rst        (rst),
      .active     (active),
      .mem_words  (mem_lim),
      .rdata      (rdata),
      .rd_src     (rd_src),
      .rd_addr    (rd_addr),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_data  (dout_data),
      .dout_src   (dout_src),
      .dout_addr  (dout_addr),
      .dout_last  (dout_last),
      .fin        (fin)
   );

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Bench for run_dump_ctrl: models the CPU halt, RF and DMEM, and checks run/dump behaviour.
module tb_run_dump_ctrl;

   localparam int DATA_W     = 32;
   localparam int RF_AW      = 5;
   localparam int MEM_AW     = 16;
   localparam int CNT_W      = 32;
   localparam int RST_CYCLES = 2;
   localparam int RF_N       = 1 << RF_AW;

   typedef struct {
      int unsigned mx;
      int unsigned mw;
      int unsigned ha;
      bit          rnd;
      bit          hold;
      int unsigned exp_cnt;
      bit          exp_to;
      int unsigned exp_beats;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  max_cycles;
   logic [MEM_AW:0]   mem_words;
   logic              cpu_rst_n;
   logic              cpu_en;
   logic              cpu_halt;
   logic [RF_AW-1:0]  rf_raddr;
   logic [DATA_W-1:0] rf_rdata;
   logic [MEM_AW-1:0] dm_raddr;
   logic [DATA_W-1:0] dm_rdata;
   logic              dout_valid;
   logic              dout_ready;
   logic [DATA_W-1:0] dout_data;
   logic              dout_src;
   logic [MEM_AW-1:0] dout_addr;
   logic              dout_last;
   logic              done;
   logic              timeout;
   logic [CNT_W-1:0]  cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] rf_mem [RF_N];
   int unsigned       halt_at  = 0;
   int unsigned       run_seen = 0;

   always #5 clk = ~clk;

   run_dump_ctrl #(
      .DATA_W(DATA_W), .RF_AW(RF_AW), .MEM_AW(MEM_AW), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .max_cycles(max_cycles), .mem_words(mem_words),
      .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en), .cpu_halt(cpu_halt),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
      .dout_src(dout_src), .dout_addr(dout_addr), .dout_last(dout_last),
      .done(done), .timeout(timeout), .cycle_count(cycle_count)
   );

   function automatic logic [DATA_W-1:0] dm_word(input logic [MEM_AW-1:0] a);
      return {a, ~a} ^ 32'h5A5A_1234;
   endfunction

   // CPU model: counts enabled cycles since its reset released, raises halt on the chosen one.
   assign rf_rdata = rf_mem[rf_raddr];
   assign dm_rdata = dm_word(dm_raddr);
   assign cpu_halt = (halt_at != 0) && cpu_en && (run_seen == halt_at - 1);

   always @(posedge clk) begin
      if (!cpu_rst_n)  run_seen <= 0;
      else if (cpu_en) run_seen <= run_seen + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input logic s, input logic [MEM_AW-1:0] a,
                                      input logic [DATA_W-1:0] d, input logic l);
      return {14'b0, s, a, d, l};
   endfunction

   // Reference outcome from the run rules: halt wins if it arrives no later than the limit.
   function automatic vec_t model(input int unsigned mx, input int unsigned mw,
                                  input int unsigned ha, input bit rnd, input bit hold);
      vec_t v;
      v.mx = mx; v.mw = mw; v.ha = ha; v.rnd = rnd; v.hold = hold;
      if (ha != 0 && (mx == 0 || ha <= mx)) begin
         v.exp_cnt = ha; v.exp_to = 1'b0;
      end else begin
         v.exp_cnt = mx; v.exp_to = 1'b1;
      end
      v.exp_beats = RF_N + mw;
      return v;
   endfunction

   task automatic run_case(input vec_t v, input string nm);
      logic [63:0] exp_q[$];
      logic [63:0] cur, held;
      bit held_v, fin, seen_en;
      int n, cyc, en_off, first_v, rst_lo;
      for (int i = 0; i < RF_N; i++)
         exp_q.push_back(pk(1'b0, MEM_AW'(i), rf_mem[i], 1'b0));
      for (int j = 0; j < int'(v.mw); j++)
         exp_q.push_back(pk(1'b1, MEM_AW'(j), dm_word(MEM_AW'(j)), 1'b0));
      exp_q[exp_q.size()-1][0] = 1'b1;

      @(posedge clk); #1;
      halt_at = v.ha; start = 1'b1; max_cycles = CNT_W'(v.mx);
      mem_words = (MEM_AW+1)'(v.mw); dout_ready = 1'b1;
      n = 0; cyc = 0; held_v = 0; fin = 0; seen_en = 0; en_off = -1; first_v = -1; rst_lo = 0;
      held = '0;
      while (!fin && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (!v.hold) start = 1'b0;
         if (done) begin
            start = 1'b0;
            fin = 1;
         end else begin
            if (!cpu_rst_n) rst_lo++;
            if (cpu_en) seen_en = 1;
            else if (seen_en && en_off < 0) en_off = cyc;
            if (dout_valid && first_v < 0) first_v = cyc;
            cur = pk(dout_src, dout_addr, dout_data, dout_last);
            if (held_v) chk({nm, " stall_hold"}, {dout_valid, cur}, {1'b1, held});
            dout_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held_v = dout_valid && !dout_ready;
            held = cur;
            if (dout_valid && dout_ready) begin
               if (n < exp_q.size()) chk({nm, " beat"}, cur, exp_q[n]);
               else chk({nm, " extra_beat"}, 1, 0);
               n++;
            end
         end
      end
      chk({nm, " done"}, done, 1);
      chk({nm, " reset_len"}, rst_lo, RST_CYCLES);
      chk({nm, " cycle_count"}, cycle_count, v.exp_cnt);
      chk({nm, " timeout"}, timeout, v.exp_to);
      chk({nm, " en_cycles"}, run_seen, v.exp_cnt);
      chk({nm, " beats"}, n, v.exp_beats);
      chk({nm, " first_valid_lat"}, first_v, en_off + 1);
      if (!v.rnd) chk({nm, " throughput"}, cyc - first_v, v.exp_beats);
   endtask

   vec_t tbl [7];

   initial begin
      int n, cyc;
      vec_t rv;
      for (int i = 0; i < RF_N; i++) rf_mem[i] = $urandom;
      tbl[0] = '{0,  4, 7,  1'b0, 1'b0, 7,  1'b0, 36};
      tbl[1] = '{10, 2, 0,  1'b0, 1'b0, 10, 1'b1, 34};
      tbl[2] = '{5,  1, 5,  1'b0, 1'b0, 5,  1'b0, 33};
      tbl[3] = '{0,  3, 12, 1'b1, 1'b1, 12, 1'b0, 35};
      tbl[4] = '{0,  0, 3,  1'b0, 1'b0, 3,  1'b0, 32};
      tbl[5] = '{4,  0, 0,  1'b1, 1'b0, 4,  1'b1, 32};
      tbl[6] = '{20, 5, 25, 1'b1, 1'b1, 20, 1'b1, 37};

      rst = 1'b1; start = 1'b0; max_cycles = '0; mem_words = '0; dout_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_cpu_rst_n", cpu_rst_n, 0);
      chk("reset_cpu_en", cpu_en, 0);
      chk("reset_outputs", {dout_valid, dout_last, done, timeout}, 0);
      chk("reset_count", cycle_count, 0);
      chk("reset_addr_data", {rf_raddr, dm_raddr, dout_addr, dout_data}, 0);

      for (int k = 0; k < 7; k++) run_case(tbl[k], $sformatf("vec%0d", k));

      for (int k = 0; k < 5; k++) begin
         int unsigned ha, mx;
         ha = $urandom_range(0, 15);
         mx = $urandom_range(0, 15);
         if (ha == 0 && mx == 0) ha = 4;
         rv = model(mx, $urandom_range(0, 5), ha, 1'b1, 1'($urandom_range(0, 1)));
         run_case(rv, $sformatf("rand%0d", k));
      end

      // Abort mid register dump: reset must drop the stream and return to idle at once.
      @(posedge clk); #1;
      halt_at = 3; start = 1'b1; max_cycles = '0; mem_words = 17'd4; dout_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0; cyc = 0;
      while (n < 10 && cyc < 200) begin
         if (dout_valid && dout_ready) n++;
         @(posedge clk); #1;
         cyc++;
      end
      chk("abort_reached_beat10", n, 10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_valid", dout_valid, 0);
      chk("abort_cpu_rst_n", cpu_rst_n, 0);
      chk("abort_done", done, 0);
      chk("abort_idle", {cpu_en, timeout, cycle_count}, 0);
      n = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (dout_valid || cpu_rst_n) n++;
      end
      chk("abort_stays_idle", n, 0);

      run_case(model(0, 2, 6, 1'b0, 1'b0), "after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
